// File: rtl/mem_stall_responder.sv
// Memory-side responder: single-line buffer models hit/miss timing in front of a
// 16-bit word backing store; answers one Rd/Wr at a time with Done/Stall/CacheHit/Err.
module mem_stall_responder #(
  parameter int ADDR_W_WORDS = 8,
  parameter int LINE_LOG2    = 2,
  parameter int MISS_LAT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        Err
);

  localparam int          TAG_W = 15 - LINE_LOG2;
  localparam int unsigned DEPTH = 1 << ADDR_W_WORDS;
  localparam logic [3:0]  CNT_LOAD = 4'(MISS_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT state, nextState;

  logic [15:0]             mem [DEPTH];
  logic                    lineValid;
  logic [TAG_W-1:0]        lineTag;
  logic [ADDR_W_WORDS-1:0] capIdx;
  logic [TAG_W-1:0]        capTag;
  logic [15:0]             capData;
  logic                    capWr;
  logic [3:0]              missCnt;

  logic                    req, badReq, hit;
  logic [TAG_W-1:0]        reqTag;
  logic [ADDR_W_WORDS-1:0] reqIdx;

  always_comb begin
    req    = Rd | Wr;
    badReq = (Rd & Wr) | Addr[0];
    reqTag = Addr[15:LINE_LOG2+1];
    reqIdx = Addr[ADDR_W_WORDS:1];
    hit    = lineValid && (lineTag == reqTag);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req && !badReq) nextState = hit ? RESP : BUSY;
      BUSY:    if (missCnt == '0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Stall = (state == BUSY);
  end

  // Done/CacheHit/DataOut are loaded on the edge entering RESP so they are
  // valid exactly for the RESP cycle; the write commits on the edge leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      DataOut   <= '0;
      Done      <= 1'b0;
      CacheHit  <= 1'b0;
      Err       <= 1'b0;
      lineValid <= 1'b0;
      lineTag   <= '0;
      capIdx    <= '0;
      capTag    <= '0;
      capData   <= '0;
      capWr     <= 1'b0;
      missCnt   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W_WORDS-1:0]] <= '0;
    end else begin
      DataOut  <= '0;
      Done     <= 1'b0;
      CacheHit <= 1'b0;
      Err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (badReq) begin
              Err <= 1'b1;
            end else begin
              capIdx  <= reqIdx;
              capTag  <= reqTag;
              capData <= DataIn;
              capWr   <= Wr;
              if (hit) begin
                Done     <= 1'b1;
                CacheHit <= 1'b1;
                DataOut  <= Wr ? '0 : mem[reqIdx];
              end else begin
                missCnt <= CNT_LOAD;
              end
            end
          end
        end
        BUSY: begin
          if (missCnt == '0) begin
            Done      <= 1'b1;
            lineValid <= 1'b1;
            lineTag   <= capTag;
            DataOut   <= capWr ? '0 : mem[capIdx];
          end else begin
            missCnt <= missCnt - 4'd1;
          end
        end
        RESP: begin
          if (capWr) mem[capIdx] <= capData;
        end
        default: ;
      endcase
    end
  end

endmodule
